// File: rtl/dsp_cfg_pkg.sv
// Shared definitions for the DSP configuration chain loader: FSM encoding and
// the CRC-16-CCITT constants used to sign the shifted frame.
package dsp_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One serial step of x^16+x^12+x^5+1, MSB-first feedback.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/cfg_crc16_serial.sv
// Serial CRC-16-CCITT accumulator; one bit folded per enabled cycle.
module cfg_crc16_serial
    import dsp_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        RST_N,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            crc <= CRC16_INIT;
        end else if (clr) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end
    end

endmodule

// File: rtl/dsp_config_chain_loader.sv
// Master end of a DSP slice configuration scan chain: serialises a word stream
// into the chain and optionally rotates it once to check a CRC of the readback.
module dsp_config_chain_loader
    import dsp_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 4,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              RST_N,
    input  logic              start,
    input  logic              verify_en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              cfg_out,
    output logic              cfg_en,
    input  logic              cfg_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam int               FILL_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);

    state_t              state;
    state_t              state_nxt;
    logic                verify_lat;
    logic [WORD_W-1:0]   wbuf;
    logic [FILL_W-1:0]   fill;
    logic [FILL_W-1:0]   fill_load;
    logic [CNT_W-1:0]    remaining;
    logic                buf_has;
    logic                accept;
    logic                start_acc;
    logic                phase_end;
    logic                shift_tx;
    logic                shift_rx;
    logic [15:0]         crc_tx;
    logic [15:0]         crc_rx;

    assign remaining = LEN_C - bit_cnt;
    assign buf_has   = (fill != '0);
    assign phase_end = (bit_cnt == LEN_C);
    assign start_acc = (state == ST_IDLE) && start;
    assign s_ready   = (state == ST_LOAD) && !buf_has && (remaining != '0);
    assign accept    = s_valid && s_ready;
    assign shift_tx  = (state == ST_LOAD) && buf_has;
    assign shift_rx  = (state == ST_VERIFY) && !phase_end;
    assign busy      = (state == ST_LOAD) || (state == ST_VERIFY);
    assign done      = (state == ST_DONE);

    // The last word only contributes the bits still owed to the chain; its
    // upper bits are never counted, so they fall out when fill reaches zero.
    always_comb begin
        fill_load = FILL_W'(WORD_W);
        if (int'(remaining) < WORD_W) begin
            fill_load = FILL_W'(remaining);
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_en    = 1'b0;
        cfg_out   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (shift_tx) begin
                    cfg_en  = 1'b1;
                    cfg_out = wbuf[0];
                end
                if (phase_end) begin
                    state_nxt = verify_lat ? ST_VERIFY : ST_DONE;
                end
            end
            ST_VERIFY: begin
                // Feeding the chain's own output back in rotates it once and
                // leaves the loaded frame in place.
                if (phase_end) begin
                    state_nxt = ST_DONE;
                end else begin
                    cfg_en  = 1'b1;
                    cfg_out = cfg_in;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            verify_lat <= 1'b0;
            fill       <= '0;
            bit_cnt    <= '0;
            error      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                verify_lat <= verify_en;
                error      <= 1'b0;
                bit_cnt    <= '0;
                fill       <= '0;
            end else if (state == ST_LOAD) begin
                if (accept) begin
                    fill <= fill_load;
                end else if (shift_tx) begin
                    fill    <= fill - 1'b1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (phase_end && verify_lat) begin
                    bit_cnt <= '0;
                end
            end else if (state == ST_VERIFY) begin
                if (phase_end) begin
                    error <= (crc_rx != crc_tx);
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // Word buffer contents carry no control meaning, so they are left unreset.
    always_ff @(posedge clk) begin
        if (accept) begin
            wbuf <= s_data;
        end else if (shift_tx) begin
            wbuf <= wbuf >> 1;
        end
    end

    cfg_crc16_serial u_crc_tx (
        .clk   (clk),
        .RST_N (RST_N),
        .clr   (start_acc),
        .en    (shift_tx),
        .din   (cfg_out),
        .crc   (crc_tx)
    );

    cfg_crc16_serial u_crc_rx (
        .clk   (clk),
        .RST_N (RST_N),
        .clr   (start_acc),
        .en    (shift_rx),
        .din   (cfg_in),
        .crc   (crc_rx)
    );

endmodule

// File: tb/tb_dsp_config_chain_loader.sv
// Bench for dsp_config_chain_loader driving a 20-bit modelled slice chain.
module tb_dsp_config_chain_loader;

    localparam int N  = 20;
    localparam int W  = 8;
    localparam int CW = $clog2(N + 1);

    logic          clk       = 1'b0;
    logic          RST_N     = 1'b0;
    logic          start     = 1'b0;
    logic          verify_en = 1'b0;
    logic          s_valid   = 1'b0;
    logic [W-1:0]  s_data    = '0;
    logic          flip      = 1'b0;
    logic          s_ready;
    logic          cfg_out;
    logic          cfg_en;
    logic          cfg_in;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] bit_cnt;
    logic [N-1:0]  chain     = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Chain of slice config registers: index 0 is fed by the loader, N-1 drives back.
    always @(posedge clk) begin
        if (cfg_en) chain <= {chain[N-2:0], cfg_out};
    end
    assign cfg_in = chain[N-1] ^ flip;

    dsp_config_chain_loader #(.CHAIN_LEN(N), .WORD_W(W)) dut (
        .clk       (clk),
        .RST_N     (RST_N),
        .start     (start),
        .verify_en (verify_en),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .cfg_out   (cfg_out),
        .cfg_en    (cfg_en),
        .cfg_in    (cfg_in),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .bit_cnt   (bit_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] reverse_bits(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[N-1-k] = v[k];
        return r;
    endfunction

    // One complete load (and optional verify); inj>=0 inverts readback bit inj,
    // busy_start>=0 pulses start on that cycle of the operation.
    task automatic run_op(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                          input logic vfy, input int gap_lo, input int gap_hi,
                          input int inj, input int busy_start);
        logic [W-1:0]   w [3];
        logic [3*W-1:0] raw;
        logic [N-1:0]   frame;
        logic [N-1:0]   tx_val;
        logic [N-1:0]   rx_val;
        int widx, gap, hs, en_cnt, done_cnt, stalls, cyc;
        bit finished;
        w[0] = w0; w[1] = w1; w[2] = w2;
        raw = {w2, w1, w0};
        frame = raw[N-1:0];
        tx_val = '0; rx_val = '0;
        widx = 0; hs = 0; en_cnt = 0; done_cnt = 0; stalls = 0; cyc = 0;
        finished = 1'b0;
        gap = $urandom_range(gap_hi, gap_lo);
        @(negedge clk);
        start = 1'b1; verify_en = vfy; s_valid = 1'b0;
        while (!finished && cyc < 600) begin
            @(negedge clk);
            start = (cyc == busy_start);
            verify_en = 1'($urandom);
            flip = (inj >= 0) && (en_cnt == N + inj);
            if (widx < 3 && gap == 0) begin
                s_valid = 1'b1; s_data = w[widx];
            end else begin
                s_valid = 1'b0; s_data = W'($urandom);
            end
            #1;
            if (cyc == 0) begin
                check("entry_bit_cnt", 32'(bit_cnt), 32'(0));
                check("start_clears_error", 32'(error), 32'(0));
                check("busy_in_load", 32'(busy), 32'(1));
            end
            if (s_valid && s_ready) begin
                hs++; widx++;
                gap = $urandom_range(gap_hi, gap_lo);
            end else if (!s_valid && gap > 0) begin
                gap--;
            end
            if (cfg_en) begin
                if (en_cnt < N) tx_val[en_cnt] = cfg_out;
                else if (en_cnt < 2 * N) rx_val[en_cnt-N] = cfg_in;
                en_cnt++;
            end else if (busy && en_cnt > 0 && en_cnt < N) begin
                stalls++;
            end
            if (done) begin
                done_cnt++;
                check("done_bit_cnt", 32'(bit_cnt), 32'(N));
                check("done_error", 32'(error), 32'(vfy && inj >= 0));
                check("done_not_busy", 32'(busy), 32'(0));
            end else if (done_cnt > 0) begin
                finished = 1'b1;
            end
            cyc++;
        end
        flip = 1'b0; s_valid = 1'b0; start = 1'b0;
        check("op_completed", 32'(finished), 32'(1));
        check("done_pulses", 32'(done_cnt), 32'(1));
        check("handshakes", 32'(hs), 32'(3));
        check("shift_count", 32'(en_cnt), 32'(vfy ? 2 * N : N));
        check("tx_bits", 32'(tx_val), 32'(frame));
        if (inj < 0) check("chain_contents", 32'(chain), 32'(reverse_bits(frame)));
        if (vfy && inj < 0) check("readback_bits", 32'(rx_val), 32'(frame));
        if (gap_lo > W + 1) check("stall_seen", 32'(stalls > 0), 32'(1));
    endtask

    task automatic reset_mid_load();
        bit hit, took;
        int dn;
        hit = 1'b0; took = 1'b0; dn = 0;
        @(negedge clk);
        start = 1'b1; verify_en = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b1; s_data = W'($urandom);
        for (int i = 0; i < 40 && !hit; i++) begin
            #1;
            if (s_valid && s_ready) took = 1'b1;
            if (bit_cnt == CW'(2)) begin
                hit = 1'b1;
            end else begin
                @(negedge clk);
                if (took) s_valid = 1'b0;
            end
        end
        check("rst_reach_bit2", 32'(hit), 32'(1));
        RST_N = 1'b0; s_valid = 1'b0;
        @(negedge clk); #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_cfg_en", 32'(cfg_en), 32'(0));
        check("rst_bit_cnt", 32'(bit_cnt), 32'(0));
        check("rst_s_ready", 32'(s_ready), 32'(0));
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (done) dn++;
        end
        check("rst_no_done", 32'(dn), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_s_ready", 32'(s_ready), 32'(0));
        check("reset_cfg_en", 32'(cfg_en), 32'(0));
        check("reset_cfg_out", 32'(cfg_out), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_error", 32'(error), 32'(0));
        check("reset_bit_cnt", 32'(bit_cnt), 32'(0));
        RST_N = 1'b1;

        run_op(8'h3C, 8'hF0, 8'hF9, 1'b0, 0, 0, -1, -1);
        run_op(8'h3C, 8'hF0, 8'hF9, 1'b0, 12, 12, -1, -1);
        run_op(8'h3C, 8'hF0, 8'hF9, 1'b1, 0, 3, -1, -1);
        run_op(W'($urandom), W'($urandom), W'($urandom), 1'b1, 0, 3, 7, -1);
        repeat (2) @(negedge clk);
        #1;
        check("error_sticky", 32'(error), 32'(1));
        run_op(W'($urandom), W'($urandom), W'($urandom), 1'b0, 0, 2, -1, 6);
        reset_mid_load();
        run_op(W'($urandom), W'($urandom), W'($urandom), 1'b0, 0, 2, -1, -1);
        for (int r = 0; r < 10; r++) begin
            logic v;
            int   inj, bs;
            v   = 1'($urandom);
            inj = (v && ($urandom_range(2, 0) == 0)) ? int'($urandom_range(N - 1, 0)) : -1;
            bs  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(30, 1)) : -1;
            run_op(W'($urandom), W'($urandom), W'($urandom), v, 0, 10, inj, bs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
